// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU fetch port, CPU data port and BRAM-side port
// around the arbiter. The arbiter uses slave; the CPU/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic [DATA_W-1:0] i_rdata;
   logic              i_rvalid;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rvalid;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
             m_en, m_we, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
             m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the instruction-fetch
// and data ports, one transaction in flight, all outputs registered.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int DATA_PRIO = 1
) (
   input  logic               aclk,
   input  logic               areset,
   mem_port_arbiter_if.slave  bus
);
   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("mem_port_arbiter: RD_LAT must be within 1..4");
      end
   endgenerate

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        lat_q, lat_d;
   logic              win_data_q, win_data_d;
   logic              wr_q, wr_d;
   logic              last_inst_q, last_inst_d;
   logic              m_en_q, m_en_d;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              i_gnt_q, i_gnt_d;
   logic              d_gnt_q, d_gnt_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              pick_data;

   always_comb begin
      // Round-robin: on a tie the port that was not granted last wins.
      if (DATA_PRIO != 0) begin
         pick_data = bus.d_req;
      end else begin
         pick_data = bus.d_req && (!bus.i_req || last_inst_q);
      end

      state_d     = state_q;
      lat_d       = lat_q;
      win_data_d  = win_data_q;
      wr_d        = wr_q;
      last_inst_d = last_inst_q;
      m_en_d      = 1'b0;
      m_we_d      = 1'b0;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      i_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               state_d     = ISSUE;
               win_data_d  = pick_data;
               last_inst_d = !pick_data;
               wr_d        = pick_data && bus.d_we;
               m_en_d      = 1'b1;
               m_we_d      = pick_data && bus.d_we;
               m_addr_d    = pick_data ? bus.d_addr : bus.i_addr;
               if (pick_data) begin
                  m_wdata_d = bus.d_wdata;
               end
               d_gnt_d     = pick_data;
               i_gnt_d     = !pick_data;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               lat_d   = LAT_INIT;
            end
         end
         WAIT: begin
            if (lat_q == 2'd0) begin
               state_d = RESP;
               if (win_data_q) begin
                  d_rdata_d  = bus.m_rdata;
                  d_rvalid_d = 1'b1;
               end else begin
                  i_rdata_d  = bus.m_rdata;
                  i_rvalid_d = 1'b1;
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         lat_q       <= 2'd0;
         win_data_q  <= 1'b0;
         wr_q        <= 1'b0;
         last_inst_q <= 1'b1;
         m_en_q      <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         i_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         win_data_q  <= win_data_d;
         wr_q        <= wr_d;
         last_inst_q <= last_inst_d;
         m_en_q      <= m_en_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         i_gnt_q     <= i_gnt_d;
         d_gnt_q     <= d_gnt_d;
         i_rvalid_q  <= i_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.m_en     = m_en_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.i_gnt    = i_gnt_q;
   assign bus.d_gnt    = d_gnt_q;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (round-robin RD_LAT=2, data-priority RD_LAT=1) each with a BRAM model;
// table-driven single transactions plus hand sequences, checked through a scoreboard.
module tb_mem_port_arbiter;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   typedef struct {
      logic        d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } iss_t;

   typedef struct {
      int   cyc;
      logic d;
   } log_t;

   logic clk = 1'b0;
   logic areset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .DATA_PRIO(0)) dut_a (
      .aclk(clk), .areset(areset), .bus(bus_a)
   );
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .DATA_PRIO(1)) dut_b (
      .aclk(clk), .areset(areset), .bus(bus_b)
   );

   // Unwritten words read as 0xDEADBEEF + (addr - 0x10).
   function automatic logic [31:0] dflt(input logic [31:0] a);
      return 32'hDEADBEEF + a - 32'h10;
   endfunction

   logic [31:0] mem_a [64];
   logic [63:0] vld_a = '0;
   logic [31:0] pipe_a [LAT_A];
   logic [31:0] mem_b [64];
   logic [63:0] vld_b = '0;
   logic [31:0] pipe_b [LAT_B];

   always @(posedge clk) begin
      if (bus_a.m_en && bus_a.m_we) begin
         mem_a[bus_a.m_addr[7:2]] <= bus_a.m_wdata;
         vld_a[bus_a.m_addr[7:2]] <= 1'b1;
      end
      if (bus_a.m_en && !bus_a.m_we)
         pipe_a[0] <= vld_a[bus_a.m_addr[7:2]] ? mem_a[bus_a.m_addr[7:2]] : dflt(bus_a.m_addr);
      else
         pipe_a[0] <= 32'hBAD0BAD0;
      for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
   end
   assign bus_a.m_rdata = pipe_a[LAT_A-1];

   always @(posedge clk) begin
      if (bus_b.m_en && bus_b.m_we) begin
         mem_b[bus_b.m_addr[7:2]] <= bus_b.m_wdata;
         vld_b[bus_b.m_addr[7:2]] <= 1'b1;
      end
      if (bus_b.m_en && !bus_b.m_we)
         pipe_b[0] <= vld_b[bus_b.m_addr[7:2]] ? mem_b[bus_b.m_addr[7:2]] : dflt(bus_b.m_addr);
      else
         pipe_b[0] <= 32'hBAD0BAD0;
      for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
   end
   assign bus_b.m_rdata = pipe_b[LAT_B-1];

   iss_t        iss_q   [2][$];
   logic [31:0] exp_i_q [2][$];
   logic [31:0] exp_d_q [2][$];
   log_t        gnt_log [2][$];
   logic [31:0] mdl_a_i = '0;
   logic [31:0] mdl_a_d = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic mon(input int w, input string p, input logic ig, input logic dg,
                      input logic men, input logic mwe, input logic [31:0] maddr,
                      input logic [31:0] mwdata, input logic irv, input logic drv,
                      input logic [31:0] ird, input logic [31:0] drd);
      iss_t        e;
      logic [31:0] r;
      chk({p, " m_en vs gnt"}, 32'(men), 32'(ig | dg));
      chk({p, " gnt exclusive"}, 32'(ig & dg), 32'd0);
      if (ig || dg) begin
         $display("%s @%0d gnt %s addr=%h we=%0d wdata=%h", p, cyc, dg ? "D" : "I", maddr, mwe, mwdata);
         gnt_log[w].push_back('{cyc: cyc, d: dg});
         if (iss_q[w].size() == 0) begin
            chk({p, " unexpected gnt"}, 32'd1, 32'd0);
         end else begin
            e = iss_q[w].pop_front();
            chk({p, " gnt port"}, 32'(dg), 32'(e.d));
            chk({p, " m_we"}, 32'(mwe), 32'(e.we));
            chk({p, " m_addr"}, maddr, e.addr);
            if (e.we) chk({p, " m_wdata"}, mwdata, e.wdata);
         end
      end
      if (irv) begin
         $display("%s @%0d i_rvalid rdata=%h", p, cyc, ird);
         if (exp_i_q[w].size() == 0) chk({p, " unexpected i_rvalid"}, 32'd1, 32'd0);
         else begin
            r = exp_i_q[w].pop_front();
            chk({p, " i_rdata"}, ird, r);
         end
      end
      if (drv) begin
         $display("%s @%0d d_rvalid rdata=%h", p, cyc, drd);
         if (exp_d_q[w].size() == 0) chk({p, " unexpected d_rvalid"}, 32'd1, 32'd0);
         else begin
            r = exp_d_q[w].pop_front();
            chk({p, " d_rdata"}, drd, r);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, "A", bus_a.i_gnt, bus_a.d_gnt, bus_a.m_en, bus_a.m_we, bus_a.m_addr, bus_a.m_wdata,
          bus_a.i_rvalid, bus_a.d_rvalid, bus_a.i_rdata, bus_a.d_rdata);
      mon(1, "B", bus_b.i_gnt, bus_b.d_gnt, bus_b.m_en, bus_b.m_we, bus_b.m_addr, bus_b.m_wdata,
          bus_b.i_rvalid, bus_b.d_rvalid, bus_b.i_rdata, bus_b.d_rdata);
   end

   // Called at the start of an IDLE cycle T on bus A; checks every cycle up to the next IDLE.
   task automatic run_vec(input int n, input vec_t v);
      int last;
      iss_t e;
      e = '{d: v.d, we: v.we, addr: v.addr, wdata: v.wdata};
      iss_q[0].push_back(e);
      if (!v.we) begin
         if (v.d) exp_d_q[0].push_back(v.rdata);
         else     exp_i_q[0].push_back(v.rdata);
      end
      if (v.d) begin
         bus_a.d_req = 1'b1; bus_a.d_we = v.we; bus_a.d_addr = v.addr; bus_a.d_wdata = v.wdata;
      end else begin
         bus_a.i_req = 1'b1; bus_a.i_addr = v.addr;
      end
      last = v.we ? 2 : LAT_A + 3;
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d i_gnt k%0d", n, k), 32'(bus_a.i_gnt), 32'(k == 1 && !v.d));
         chk($sformatf("v%0d d_gnt k%0d", n, k), 32'(bus_a.d_gnt), 32'(k == 1 && v.d));
         chk($sformatf("v%0d i_rvalid k%0d", n, k), 32'(bus_a.i_rvalid),
             32'(!v.we && !v.d && k == LAT_A + 2));
         chk($sformatf("v%0d d_rvalid k%0d", n, k), 32'(bus_a.d_rvalid),
             32'(!v.we && v.d && k == LAT_A + 2));
         if (k == 1) begin
            @(posedge clk); #1;
            bus_a.i_req = 1'b0; bus_a.d_req = 1'b0;
         end
      end
      if (!v.we) begin
         if (v.d) mdl_a_d = v.rdata;
         else     mdl_a_i = v.rdata;
      end
      chk($sformatf("v%0d hold i_rdata", n), bus_a.i_rdata, mdl_a_i);
      chk($sformatf("v%0d hold d_rdata", n), bus_a.d_rdata, mdl_a_d);
      @(posedge clk); #1;
   endtask

   vec_t vecs [7];
   int   n;

   initial begin
      vecs[0] = '{d: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,        rdata: 32'hDEADBEEF};
      vecs[1] = '{d: 1'b1, we: 1'b1, addr: 32'h40, wdata: 32'h1234,     rdata: 32'h0};
      vecs[2] = '{d: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0,        rdata: 32'h00001234};
      vecs[3] = '{d: 1'b0, we: 1'b0, addr: 32'h44, wdata: 32'h0,        rdata: 32'hDEADBF23};
      vecs[4] = '{d: 1'b1, we: 1'b0, addr: 32'h00, wdata: 32'h0,        rdata: 32'hDEADBEDF};
      vecs[5] = '{d: 1'b1, we: 1'b1, addr: 32'hFC, wdata: 32'hFFFFFFFF, rdata: 32'h0};
      vecs[6] = '{d: 1'b0, we: 1'b0, addr: 32'hFC, wdata: 32'h0,        rdata: 32'hFFFFFFFF};

      // Reset held with both requests asserted.
      areset = 1'b1;
      bus_a.i_req = 1'b1; bus_a.i_addr = 32'h0; bus_a.d_req = 1'b1; bus_a.d_we = 1'b0;
      bus_a.d_addr = 32'h0; bus_a.d_wdata = 32'h0;
      bus_b.i_req = 1'b1; bus_b.i_addr = 32'h0; bus_b.d_req = 1'b1; bus_b.d_we = 1'b0;
      bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0;
      repeat (3) begin
         @(negedge clk);
         chk("rst quiet A", 32'({bus_a.m_en, bus_a.i_gnt, bus_a.d_gnt, bus_a.i_rvalid, bus_a.d_rvalid}), 32'd0);
         chk("rst quiet B", 32'({bus_b.m_en, bus_b.i_gnt, bus_b.d_gnt, bus_b.i_rvalid, bus_b.d_rvalid}), 32'd0);
      end
      @(posedge clk); #1;
      bus_a.i_req = 1'b0; bus_a.d_req = 1'b0; bus_b.i_req = 1'b0; bus_b.d_req = 1'b0;
      areset = 1'b0;
      @(negedge clk);
      chk("rst A i_rdata", bus_a.i_rdata, 32'd0);
      chk("rst A d_rdata", bus_a.d_rdata, 32'd0);
      chk("rst B i_rdata", bus_b.i_rdata, 32'd0);
      chk("rst B d_rdata", bus_b.d_rdata, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Round-robin with both ports holding reads: D,I,D,I spaced RD_LAT+3.
      gnt_log[0].delete();
      for (int j = 0; j < 2; j++) begin
         iss_q[0].push_back('{d: 1'b1, we: 1'b0, addr: 32'h80, wdata: 32'h0});
         iss_q[0].push_back('{d: 1'b0, we: 1'b0, addr: 32'h84, wdata: 32'h0});
         exp_d_q[0].push_back(32'hDEADBF5F);
         exp_i_q[0].push_back(32'hDEADBF63);
      end
      bus_a.d_we = 1'b0; bus_a.d_addr = 32'h80; bus_a.i_addr = 32'h84;
      bus_a.d_req = 1'b1; bus_a.i_req = 1'b1;
      n = 0;
      for (int t = 0; t < 80 && n < 4; t++) begin
         @(negedge clk);
         if (bus_a.i_gnt || bus_a.d_gnt) n++;
      end
      chk("A rr grant count", 32'(n), 32'd4);
      @(posedge clk); #1;
      bus_a.d_req = 1'b0; bus_a.i_req = 1'b0;
      repeat (LAT_A + 4) @(negedge clk);
      chk("A rr log size", 32'(gnt_log[0].size()), 32'd4);
      for (int j = 0; j < 4 && j < gnt_log[0].size(); j++) begin
         chk($sformatf("A rr order %0d", j), 32'(gnt_log[0][j].d), 32'(j % 2 == 0));
         if (j > 0)
            chk($sformatf("A rr spacing %0d", j), 32'(gnt_log[0][j].cyc - gnt_log[0][j-1].cyc), 32'(LAT_A + 3));
      end
      mdl_a_d = 32'hDEADBF5F; mdl_a_i = 32'hDEADBF63;
      @(posedge clk); #1;

      // Reset during WAIT of a data read; pending i_req granted after release.
      iss_q[0].push_back('{d: 1'b1, we: 1'b0, addr: 32'h08, wdata: 32'h0});
      iss_q[0].push_back('{d: 1'b0, we: 1'b0, addr: 32'h0C, wdata: 32'h0});
      exp_i_q[0].push_back(32'hDEADBEEB);
      bus_a.d_we = 1'b0; bus_a.d_addr = 32'h08; bus_a.d_req = 1'b1;
      bus_a.i_addr = 32'h0C; bus_a.i_req = 1'b1;
      @(negedge clk);
      chk("rst5 d_gnt T", 32'(bus_a.d_gnt), 32'd0);
      @(negedge clk);
      chk("rst5 d_gnt T+1", 32'(bus_a.d_gnt), 32'd1);
      chk("rst5 i_gnt T+1", 32'(bus_a.i_gnt), 32'd0);
      @(posedge clk); #1;
      bus_a.d_req = 1'b0; areset = 1'b1;
      @(negedge clk);
      chk("rst5 i_gnt in WAIT", 32'(bus_a.i_gnt), 32'd0);
      @(posedge clk); #1;
      areset = 1'b0;
      @(negedge clk);
      chk("rst5 outputs cleared", 32'({bus_a.m_en, bus_a.i_gnt, bus_a.d_gnt, bus_a.i_rvalid, bus_a.d_rvalid}), 32'd0);
      chk("rst5 i_rdata cleared", bus_a.i_rdata, 32'd0);
      chk("rst5 d_rdata cleared", bus_a.d_rdata, 32'd0);
      @(negedge clk);
      chk("rst5 i_gnt after release", 32'(bus_a.i_gnt), 32'd1);
      @(posedge clk); #1;
      bus_a.i_req = 1'b0;
      repeat (LAT_A + 3) @(negedge clk);
      chk("rst5 i_rdata", bus_a.i_rdata, 32'hDEADBEEB);
      chk("rst5 d_rdata stays 0", bus_a.d_rdata, 32'd0);
      @(posedge clk); #1;

      // Fixed data priority: continuous requests give D,D,D and no i_gnt.
      gnt_log[1].delete();
      for (int j = 0; j < 3; j++) begin
         iss_q[1].push_back('{d: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0});
         exp_d_q[1].push_back(32'hDEADBEFF);
      end
      bus_b.d_we = 1'b0; bus_b.d_addr = 32'h20; bus_b.i_addr = 32'h24;
      bus_b.d_req = 1'b1; bus_b.i_req = 1'b1;
      n = 0;
      for (int t = 0; t < 80 && n < 3; t++) begin
         @(negedge clk);
         if (bus_b.i_gnt || bus_b.d_gnt) n++;
      end
      chk("B prio grant count", 32'(n), 32'd3);
      @(posedge clk); #1;
      bus_b.d_req = 1'b0; bus_b.i_req = 1'b0;
      repeat (LAT_B + 4) @(negedge clk);
      chk("B prio log size", 32'(gnt_log[1].size()), 32'd3);
      for (int j = 0; j < 3 && j < gnt_log[1].size(); j++) begin
         chk($sformatf("B prio port %0d", j), 32'(gnt_log[1][j].d), 32'd1);
         if (j > 0)
            chk($sformatf("B prio spacing %0d", j), 32'(gnt_log[1][j].cyc - gnt_log[1][j-1].cyc), 32'(LAT_B + 3));
      end
      @(posedge clk); #1;

      // Back-to-back writes then a read on the data port, request held throughout.
      gnt_log[1].delete();
      iss_q[1].push_back('{d: 1'b1, we: 1'b1, addr: 32'h10, wdata: 32'h11});
      iss_q[1].push_back('{d: 1'b1, we: 1'b1, addr: 32'h14, wdata: 32'h22});
      iss_q[1].push_back('{d: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0});
      exp_d_q[1].push_back(32'h11);
      for (int s = 0; s < 3; s++) begin
         bus_b.d_req = 1'b1;
         bus_b.d_we = (s < 2);
         bus_b.d_addr = (s == 1) ? 32'h14 : 32'h10;
         bus_b.d_wdata = (s == 0) ? 32'h11 : ((s == 1) ? 32'h22 : 32'h0);
         n = 0;
         for (int t = 0; t < 20 && n == 0; t++) begin
            @(negedge clk);
            if (bus_b.d_gnt) n = 1;
         end
         chk($sformatf("B b2b gnt step %0d", s), 32'(n), 32'd1);
         @(posedge clk); #1;
      end
      bus_b.d_req = 1'b0;
      repeat (LAT_B + 4) @(negedge clk);
      chk("B b2b log size", 32'(gnt_log[1].size()), 32'd3);
      for (int j = 1; j < 3 && j < gnt_log[1].size(); j++)
         chk($sformatf("B b2b spacing %0d", j), 32'(gnt_log[1][j].cyc - gnt_log[1][j-1].cyc), 32'd2);
      chk("B b2b d_rdata", bus_b.d_rdata, 32'h11);
      chk("B other i_rdata", bus_b.i_rdata, 32'd0);

      chk("A pending issues", 32'(iss_q[0].size()), 32'd0);
      chk("B pending issues", 32'(iss_q[1].size()), 32'd0);
      chk("A pending i reads", 32'(exp_i_q[0].size()), 32'd0);
      chk("A pending d reads", 32'(exp_d_q[0].size()), 32'd0);
      chk("B pending i reads", 32'(exp_i_q[1].size()), 32'd0);
      chk("B pending d reads", 32'(exp_d_q[1].size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
